// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/halt/step sequencer for the pipelined RISC-V CPU. It owns the CPU's
//   active-high reset and its clock-enable, watches the fetch PC for a single
//   breakpoint, and counts cycles in which the CPU was allowed to advance.
//
// Ports
//   clk, rst           system clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (accepted on valid & ready at posedge)
//   cmd_op             0 HALT, 1 RUN, 2 STEP, 3 RESET_CPU
//   cmd_count          STEP length in enabled cycles (0 behaves as 1)
//   bp_en, bp_addr     PC breakpoint
//   pc                 CPU fetch PC
//   cpu_en             CPU clock-enable (combinational)
//   cpu_rst            CPU reset (registered)
//   halted             sequencer is in HALTED
//   halt_cause         0 command, 1 breakpoint, 2 step done, 3 boot
//   cycle_count        number of cycles with cpu_en = 1 (wraps)
module cpu_run_ctrl #(
   parameter int RST_CYCLES = 4,
   parameter bit BOOT_RUN   = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   output logic             cpu_en,
   output logic             cpu_rst,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [31:0]      cycle_count
);

   localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES - 1);

   localparam logic [1:0] OP_HALT  = 2'd0;
   localparam logic [1:0] OP_RUN   = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_RESET = 2'd3;

   localparam logic [1:0] HC_CMD  = 2'd0;
   localparam logic [1:0] HC_BP   = 2'd1;
   localparam logic [1:0] HC_STEP = 2'd2;
   localparam logic [1:0] HC_BOOT = 2'd3;

   typedef enum logic [1:0] {S_CPU_RESET, S_HALTED, S_RUN, S_STEP} state_t;

   state_t           state_q, state_d;
   logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic             skip_q, skip_d;
   logic             boot_q, boot_d;
   logic [31:0]      cyc_q;
   logic             clr_cnt;
   logic             acc;
   logic             bp_hit;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cpu_rst_d = cpu_rst_q;
      cause_d   = cause_q;
      step_d    = step_q;
      skip_d    = skip_q;
      boot_d    = boot_q;
      clr_cnt   = 1'b0;
      cpu_en    = 1'b0;
      cmd_ready = (state_q != S_CPU_RESET);
      acc       = cmd_valid & cmd_ready;
      // skip lets a RUN issued while parked on the breakpoint get past it once
      bp_hit    = bp_en & (pc == bp_addr) & ~skip_q;

      // RESET_CPU outranks everything else that can happen on the same edge
      if (acc && cmd_op == OP_RESET) begin
         state_d   = S_CPU_RESET;
         rst_cnt_d = RST_LOAD;
         cpu_rst_d = 1'b1;
         clr_cnt   = 1'b1;
         boot_d    = 1'b0;
      end

      unique case (state_q)
         S_CPU_RESET: begin
            if (rst_cnt_q == '0) begin
               cpu_rst_d = 1'b0;
               boot_d    = 1'b0;
               if (boot_q && BOOT_RUN) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_HALTED;
                  cause_d = boot_q ? HC_BOOT : HC_CMD;
               end
            end else begin
               rst_cnt_d = rst_cnt_q - 1'b1;
            end
         end
         S_HALTED: begin
            if (acc && cmd_op == OP_RUN) begin
               state_d = S_RUN;
               skip_d  = 1'b1;
            end else if (acc && cmd_op == OP_STEP) begin
               state_d = S_STEP;
               step_d  = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
            end
         end
         S_RUN: begin
            cpu_en = ~bp_hit;
            skip_d = 1'b0;
            if (!(acc && cmd_op == OP_RESET)) begin
               if (acc && cmd_op == OP_HALT) begin
                  state_d = S_HALTED;
                  cause_d = HC_CMD;
               end else if (bp_hit) begin
                  state_d = S_HALTED;
                  cause_d = HC_BP;
               end
            end
         end
         S_STEP: begin
            cpu_en = 1'b1;
            step_d = step_q - 1'b1;
            if (!(acc && cmd_op == OP_RESET)) begin
               if (acc && cmd_op == OP_HALT) begin
                  state_d = S_HALTED;
                  cause_d = HC_CMD;
                  step_d  = '0;
               end else if (step_q <= CNT_W'(1)) begin
                  state_d = S_HALTED;
                  cause_d = HC_STEP;
                  step_d  = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_CPU_RESET;
         rst_cnt_q <= RST_LOAD;
         cpu_rst_q <= 1'b1;
         cause_q   <= HC_BOOT;
         step_q    <= '0;
         skip_q    <= 1'b0;
         boot_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cpu_rst_q <= cpu_rst_d;
         cause_q   <= cause_d;
         step_q    <= step_d;
         skip_q    <= skip_d;
         boot_q    <= boot_d;
      end
   end

   // Counter is only written when it changes, so it holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q <= '0;
      end else if (clr_cnt) begin
         cyc_q <= '0;
      end else if (cpu_en) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end

   assign cpu_rst     = cpu_rst_q;
   assign halted      = (state_q == S_HALTED);
   assign halt_cause  = cause_q;
   assign cycle_count = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a mode-level model of the sequencer is checked
// against the DUT every cycle, and directed scenarios pin literal values.
// A tiny CPU stand-in advances pc by 4 on every enabled cycle.
module tb_cpu_run_ctrl;
   localparam int RSTC = 4;
   localparam int CW   = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'd0;
   logic [CW-1:0] cmd_count = '0;
   logic          bp_en = 1'b0;
   logic [31:0]   bp_addr = 32'd0;
   logic [31:0]   pc;
   logic          cpu_en, cpu_rst, halted;
   logic [1:0]    halt_cause;
   logic [31:0]   cycle_count;

   logic          jump_req = 1'b0;
   logic [31:0]   jump_pc = 32'd0;
   logic          preload_req = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   cpu_run_ctrl #(.RST_CYCLES(RSTC), .BOOT_RUN(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_count(cmd_count), .bp_en(bp_en), .bp_addr(bp_addr),
      .pc(pc), .cpu_en(cpu_en), .cpu_rst(cpu_rst), .halted(halted),
      .halt_cause(halt_cause), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // CPU stand-in
   always @(posedge clk) begin
      if (jump_req)     pc <= jump_pc;
      else if (cpu_rst) pc <= 32'd0;
      else if (cpu_en)  pc <= pc + 32'd4;
   end

   // ---------------- model ----------------
   typedef enum int {M_RST, M_HLT, M_RUN, M_STP} mmode_t;
   mmode_t      m_mode;
   int          m_left;     // reset edges still to come
   int          m_steps;    // enabled cycles still owed to a STEP
   logic [1:0]  m_cause;
   logic        m_skip, m_boot;
   logic [31:0] m_cnt;

   function automatic logic m_hit();
      return (m_mode == M_RUN) && bp_en && (pc == bp_addr) && !m_skip;
   endfunction
   function automatic logic m_en();
      return (m_mode == M_STP) || ((m_mode == M_RUN) && !m_hit());
   endfunction
   function automatic logic m_ready();
      return m_mode != M_RST;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode <= M_RST; m_left <= RSTC; m_cause <= 2'd3; m_steps <= 0;
         m_skip <= 1'b0;  m_boot <= 1'b1; m_cnt <= 32'd0;
      end else begin
         if (preload_req)                                 m_cnt <= 32'hFFFF_FFFF;
         else if (cmd_valid && m_ready() && cmd_op == 2'd3) m_cnt <= 32'd0;
         else if (m_en())                                 m_cnt <= m_cnt + 32'd1;

         if (m_mode == M_RST) begin
            if (m_left == 1) begin
               m_boot <= 1'b0;
               if (m_boot) m_mode <= M_RUN;
               else begin m_mode <= M_HLT; m_cause <= 2'd0; end
            end else m_left <= m_left - 1;
         end else if (cmd_valid && cmd_op == 2'd3) begin
            m_mode <= M_RST; m_left <= RSTC; m_boot <= 1'b0;
         end else begin
            if (m_mode == M_RUN) m_skip <= 1'b0;
            if (cmd_valid && cmd_op == 2'd0) begin
               if (m_mode != M_HLT) begin m_mode <= M_HLT; m_cause <= 2'd0; end
            end else if (m_mode == M_HLT && cmd_valid && cmd_op == 2'd1) begin
               m_mode <= M_RUN; m_skip <= 1'b1;
            end else if (m_mode == M_HLT && cmd_valid && cmd_op == 2'd2) begin
               m_mode <= M_STP; m_steps <= (cmd_count == '0) ? 1 : int'(cmd_count);
            end else if (m_mode == M_RUN && m_hit()) begin
               m_mode <= M_HLT; m_cause <= 2'd1;
            end else if (m_mode == M_STP) begin
               if (m_steps <= 1) begin m_mode <= M_HLT; m_cause <= 2'd2; m_steps <= 0; end
               else m_steps <= m_steps - 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // per-cycle compare against the model
   initial begin
      #2;
      forever begin
         @(posedge clk); #3;
         chk("cpu_en",      32'(cpu_en),     32'(m_en()));
         chk("cpu_rst",     32'(cpu_rst),    32'(m_mode == M_RST));
         chk("cmd_ready",   32'(cmd_ready),  32'(m_ready()));
         chk("halted",      32'(halted),     32'(m_mode == M_HLT));
         chk("halt_cause",  32'(halt_cause), 32'(m_cause));
         chk("cycle_count", cycle_count,     m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [1:0] op, input int cnt);
      cmd_valid = 1'b1; cmd_op = op; cmd_count = CW'(cnt);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b0;
      tick(2);
      chk("rst cpu_rst",   32'(cpu_rst),   32'd1);
      chk("rst cpu_en",    32'(cpu_en),    32'd0);
      chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst cause",     32'(halt_cause), 32'd3);
      chk("rst count",     cycle_count,    32'd0);

      // boot into RUN
      rst = 1'b1;
      tick(3); chk("boot rst held", 32'(cpu_rst), 32'd1);
      tick(1); chk("boot rst low", 32'(cpu_rst), 32'd0);
      chk("boot en", 32'(cpu_en), 32'd1);
      chk("boot cause", 32'(halt_cause), 32'd3);
      tick(20); chk("boot count20", cycle_count, 32'd20);
      chk("boot pc", pc, 32'h50);

      // RESET_CPU from RUN, then run into breakpoint
      send(2'd3, 0);
      tick(3); chk("rcpu held", 32'(cpu_rst), 32'd1);
      tick(1); chk("rcpu low", 32'(cpu_rst), 32'd0);
      chk("rcpu halted", 32'(halted), 32'd1);
      chk("rcpu cause", 32'(halt_cause), 32'd0);
      chk("rcpu count", cycle_count, 32'd0);
      bp_en = 1'b1; bp_addr = 32'h10;
      send(2'd1, 0);
      tick(4); chk("bp pc", pc, 32'h10);
      chk("bp en", 32'(cpu_en), 32'd0);
      tick(1); chk("bp halted", 32'(halted), 32'd1);
      chk("bp cause", 32'(halt_cause), 32'd1);
      chk("bp count", cycle_count, 32'd4);

      // resume past the breakpoint, then return to it
      send(2'd1, 0); chk("skip en", 32'(cpu_en), 32'd1);
      tick(1); chk("skip pc", pc, 32'h14);
      chk("skip count", cycle_count, 32'd5);
      tick(2);
      jump_req = 1'b1; jump_pc = 32'h10;
      tick(1); jump_req = 1'b0;
      chk("rehit en", 32'(cpu_en), 32'd0);
      chk("rehit count", cycle_count, 32'd8);
      tick(1); chk("rehit cause", 32'(halt_cause), 32'd1);
      send(2'd0, 0); chk("halt idle cause", 32'(halt_cause), 32'd1);

      // STEP 3 and STEP 0
      send(2'd2, 3); chk("step en", 32'(cpu_en), 32'd1);
      tick(3); chk("step3 halted", 32'(halted), 32'd1);
      chk("step3 cause", 32'(halt_cause), 32'd2);
      chk("step3 count", cycle_count, 32'd11);
      send(2'd2, 0); tick(1);
      chk("step0 halted", 32'(halted), 32'd1);
      chk("step0 count", cycle_count, 32'd12);

      // HALT on the same edge as a breakpoint hit
      send(2'd1, 0); tick(1);
      jump_req = 1'b1; jump_pc = 32'h10;
      tick(1); jump_req = 1'b0;
      chk("race en", 32'(cpu_en), 32'd0);
      send(2'd0, 0);
      chk("race halted", 32'(halted), 32'd1);
      chk("race cause", 32'(halt_cause), 32'd0);
      chk("race count", cycle_count, 32'd14);

      // asynchronous reset mid-STEP
      send(2'd2, 8); tick(3);
      #2 rst = 1'b0;
      #1;
      chk("arst en", 32'(cpu_en), 32'd0);
      chk("arst cpu_rst", 32'(cpu_rst), 32'd1);
      chk("arst ready", 32'(cmd_ready), 32'd0);
      chk("arst count", cycle_count, 32'd0);
      tick(2); rst = 1'b1;
      tick(3); chk("reboot held", 32'(cpu_rst), 32'd1);
      tick(1); chk("reboot en", 32'(cpu_en), 32'd1);
      tick(5); chk("reboot bp cause", 32'(halt_cause), 32'd1);
      chk("reboot count", cycle_count, 32'd4);

      // counter wrap
      preload_req = 1'b1;
      force dut.cyc_q = 32'hFFFF_FFFF;
      tick(1);
      release dut.cyc_q;
      preload_req = 1'b0;
      chk("preload", cycle_count, 32'hFFFF_FFFF);
      send(2'd2, 1); tick(1);
      chk("wrap", cycle_count, 32'd0);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
